// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_fifo and fetch_stage (optional counters: FETCH_PERF_EN).
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush.
// Supports push and pop in the same cycle, including when full.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  fetch_entry_t               i_entry,
   output fetch_entry_t               o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   fetch_entry_t mem_q [DEPTH];
   fetch_entry_t mem_d [DEPTH];

   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_head  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal alongside a pop.
   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & ~i_flush & (~o_full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed once counted.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_comb begin
         mem_d[gi] = mem_q[gi];
         if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
            mem_d[gi] = i_entry;
         end
      end

      always_ff @(posedge i_clk) begin
         mem_q[gi] <= mem_d[gi];
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem address, fetch buffer, redirects.
// Define FETCH_PERF_EN to add the fetched/flushed performance counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 13,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   input  logic [31:0]           i_imem_data,
   input  logic                  i_redirect_valid,
   input  logic [31:0]           i_redirect_pc,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [31:0]           o_instr,
`ifdef FETCH_PERF_EN
   output logic [31:0]           o_perf_fetched,
   output logic [31:0]           o_perf_flushed,
`endif
   output logic [31:0]           o_pc
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      pc_q, pc_d;
   logic             push;
   logic             pop;
   fetch_entry_t     wr_entry;
   fetch_entry_t     fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   assign o_imem_addr = pc_q[ADDR_WIDTH-1:0];

   // imem read is combinational, so the data belongs to the current pc.
   assign wr_entry = '{pc: pc_q, instr: i_imem_data};

   assign o_valid = (fifo_count != '0);
   assign o_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
   assign o_pc    = fifo_empty ? 32'd0     : fifo_head.pc;

   assign pop  = o_valid & i_ready;
   assign push = ~i_redirect_valid & (~fifo_full | pop);

   always_comb begin
      pc_d = pc_q;
      if (i_redirect_valid) begin
         pc_d = align_pc(i_redirect_pc);
      end else if (push) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_pop   (pop),
      .i_flush (i_redirect_valid),
      .i_entry (wr_entry),
      .o_head  (fifo_head),
      .o_count (fifo_count),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] flushed_q, flushed_d;

   // Entries handed to decode in the redirect cycle are not counted as flushed.
   always_comb begin
      fetched_d = fetched_q;
      flushed_d = flushed_q;
      if (push) begin
         fetched_d = fetched_q + 32'd1;
      end
      if (i_redirect_valid) begin
         flushed_d = flushed_q + 32'(fifo_count) - 32'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fetched_q <= '0;
         flushed_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         flushed_q <= flushed_d;
      end
   end

   assign o_perf_fetched = fetched_q;
   assign o_perf_flushed = flushed_q;
`endif

endmodule
